// File: rtl/brisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : brisc_pkg
// Description : Shared widths, fetch constants and fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package brisc_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_1000;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry {instr, pc} holding register that catches a fetch
//               response arriving while decode is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import brisc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [ILEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic            full,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  logic            r_full;
  logic [ILEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_full <= 1'b0;
    end else if (push) begin
      r_full <= 1'b1;
    end else if (pop) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (push) begin
      r_instr <= push_instr;
      r_pc    <= push_pc;
    end
  end

  assign full  = r_full;
  assign instr = r_instr;
  assign pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC owner and instruction-memory front end. One outstanding
//               request, one-entry skid buffer, redirect flush with drop of
//               the in-flight response. FETCH_MISALIGN_EXC_EN enables the
//               misaligned-redirect fault; otherwise target bits [1:0] are
//               forced to zero and exception stays low.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import brisc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = brisc_pkg::RESET_PC,
  parameter logic [ILEN-1:0] NOP_INSTR = brisc_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_fetch,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  output logic            exception
);

`ifdef FETCH_MISALIGN_EXC_EN
  localparam bit c_misalign_en = 1'b1;
`else
  localparam bit c_misalign_en = 1'b0;
`endif

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_pc_out;
  logic [ILEN-1:0] r_instr;
  logic            r_valid;
  logic            r_exc;
  logic            r_drop;
  logic            r_fault;

  logic            w_skid_full;
  logic [ILEN-1:0] w_skid_instr;
  logic [XLEN-1:0] w_skid_pc;

  logic [XLEN-1:0] w_target;
  logic            w_misalign;
  logic            w_can_load;
  logic            w_resp_live;
  logic            w_inflight;
  logic            w_push;
  logic            w_pop;
  logic            w_load_resp;
  logic            w_req_valid;
  logic            w_req_fire;

  assign w_target   = c_misalign_en ? redirect_pc : {redirect_pc[XLEN-1:2], 2'b00};
  assign w_misalign = c_misalign_en && redirect_valid && (redirect_pc[1:0] != 2'b00);

  assign w_can_load  = !r_valid || !stall_fetch;
  assign w_resp_live = imem_resp_valid && !r_drop && !redirect_valid && (r_state == WAIT);
  // A response arriving in the redirect cycle is the outstanding one, so nothing remains to drop.
  assign w_inflight  = ((r_state == WAIT) || r_drop) && !imem_resp_valid;
  assign w_push      = w_resp_live && !w_can_load;
  assign w_pop       = w_can_load && w_skid_full && !redirect_valid;
  assign w_load_resp = w_can_load && !w_skid_full && w_resp_live;
  assign w_req_fire  = w_req_valid && imem_req_ready;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (redirect_valid),
    .push_instr (imem_resp_data),
    .push_pc    (r_req_pc),
    .full       (w_skid_full),
    .instr      (w_skid_instr),
    .pc         (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = w_misalign ? HOLD : (w_inflight ? WAIT : REQ);
    end else begin
      case (r_state)
        REQ:     if (w_req_fire) w_state_nxt = WAIT;
        WAIT:    if (imem_resp_valid) w_state_nxt = w_push ? HOLD : REQ;
        // A faulted fetch parks here until the next redirect.
        HOLD:    if (!r_fault && (!w_skid_full || w_pop)) w_state_nxt = REQ;
        default: w_state_nxt = REQ;
      endcase
    end
  end

  always_comb begin
    w_req_valid = (r_state == REQ) && !reset && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_drop   <= 1'b0;
      r_fault  <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= w_target;
      r_drop  <= w_inflight;
      r_fault <= w_misalign;
    end else begin
      if (w_req_fire) begin
        r_pc     <= r_pc + XLEN'(4);
        r_req_pc <= r_pc;
      end
      if (imem_resp_valid && r_drop) begin
        r_drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_pc_out <= '0;
      r_exc    <= 1'b0;
    end else if (redirect_valid) begin
      r_valid <= w_misalign;
      r_instr <= NOP_INSTR;
      r_exc   <= w_misalign;
      if (w_misalign) begin
        r_pc_out <= redirect_pc;
      end
    end else if (w_can_load) begin
      if (w_pop) begin
        r_valid  <= 1'b1;
        r_instr  <= w_skid_instr;
        r_pc_out <= w_skid_pc;
        r_exc    <= 1'b0;
      end else if (w_load_resp) begin
        r_valid  <= 1'b1;
        r_instr  <= imem_resp_data;
        r_pc_out <= r_req_pc;
        r_exc    <= 1'b0;
      end else begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
        r_exc   <= 1'b0;
      end
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign instr_out      = r_instr;
  assign pc_out         = r_pc_out;
  assign instr_valid    = r_valid;
  assign exception      = r_exc;

endmodule
`default_nettype wire
